// File: rtl/apb2axi_pkg.sv
// Shared APB-to-AXI bridge types and constants: AXI widths, AR attribute constants,
// read scheduler state encoding and a generic round-robin pick helper.
package apb2axi_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] AR_BURST_INCR = 2'b01;
    localparam logic [3:0] AR_CACHE_DEF  = 4'b0011;

    // Widest requester vector the round-robin helper handles.
    localparam int unsigned RR_MAX_REQ = 8;

    typedef enum logic [0:0] {
        RS_IDLE,
        RS_HOLD
    } rd_sched_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of eligible at or after ptr, wrapping modulo n_req (ptr < n_req).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] eligible,
                                         input logic [2:0]            ptr,
                                         input int unsigned           n_req);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= n_req) begin
                j = j - n_req;
            end
            if ((k < n_req) && !res.found && eligible[3'(j)]) begin
                res.found = 1'b1;
                res.idx   = 3'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb2axi_rr_arbiter.sv
// Combinational round-robin requester pick; PRIO0 gives requester 0 fixed top priority
// and leaves the rotation to the remaining requesters.
module apb2axi_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter bit          PRIO0 = 1'b0,
    parameter int unsigned SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] pick
);
    import apb2axi_pkg::*;

    logic [RR_MAX_REQ-1:0] elig_ext;
    rr_pick_t              rr_res;

    always_comb begin
        elig_ext               = '0;
        elig_ext[N_REQ-1:0]    = eligible;
        if (PRIO0) begin
            elig_ext[0] = 1'b0;
        end
        rr_res = rr_pick(elig_ext, 3'(ptr), N_REQ);
        found  = rr_res.found;
        pick   = SEL_W'(rr_res.idx);
        if (PRIO0 && eligible[0]) begin
            found = 1'b1;
            pick  = '0;
        end
    end

endmodule

// File: rtl/apb2axi_rd_scheduler.sv
// Shares one AXI AR channel among N_REQ read sources with ARID-collision blocking and an
// outstanding-burst cap. Define APB2AXI_RD_SCHED_PRIO_EN to give requester 0 fixed priority.
module apb2axi_rd_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_OUTST  = 8,
    parameter int unsigned AXI_ADDR_W = apb2axi_pkg::AXI_ADDR_W,
    parameter int unsigned AXI_ID_W   = apb2axi_pkg::AXI_ID_W,
    parameter int unsigned SEL_W      = $clog2(N_REQ),
    parameter int unsigned CNT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*AXI_ID_W-1:0]   req_id,
    input  logic [N_REQ*4-1:0]          req_len,
    input  logic [N_REQ*3-1:0]          req_size,
    output logic [AXI_ID_W-1:0]         arid,
    output logic [AXI_ADDR_W-1:0]       araddr,
    output logic [3:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [AXI_ID_W-1:0]         rid,
    input  logic                        rvalid,
    input  logic                        rready,
    input  logic                        rlast,
    output logic [SEL_W-1:0]            rsp_sel,
    output logic [N_REQ-1:0]            rsp_done,
    output logic [CNT_W-1:0]            outst_cnt,
    output logic                        err_unexp_rid
);
    import apb2axi_pkg::*;

    localparam int unsigned ID_NUM = 2 ** AXI_ID_W;

`ifdef APB2AXI_RD_SCHED_PRIO_EN
    localparam bit PrioEn = 1'b1;
`else
    localparam bit PrioEn = 1'b0;
`endif

    rd_sched_state_e         state_q, state_d;
    logic [ID_NUM-1:0]       id_busy_q, id_busy_d;
    logic [SEL_W-1:0]        owner_tbl_q [ID_NUM];
    logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]        outst_cnt_q, outst_cnt_d;
    logic [AXI_ID_W-1:0]     arid_q, arid_d;
    logic [AXI_ADDR_W-1:0]   araddr_q, araddr_d;
    logic [3:0]              arlen_q, arlen_d;
    logic [2:0]              arsize_q, arsize_d;
    logic [N_REQ-1:0]        rsp_done_q, rsp_done_d;
    logic                    err_q, err_d;

    logic [N_REQ-1:0]        eligible;
    logic                    pick_found;
    logic [SEL_W-1:0]        pick;
    logic                    ar_hs, r_hs, rid_busy, r_done;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] & ~id_busy_q[req_id[i*AXI_ID_W +: AXI_ID_W]] &
                          (outst_cnt_q < CNT_W'(MAX_OUTST));
        end
    end

    apb2axi_rr_arbiter #(
        .N_REQ (N_REQ),
        .PRIO0 (PrioEn),
        .SEL_W (SEL_W)
    ) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .found    (pick_found),
        .pick     (pick)
    );

    // Grant pops the request immediately; the payload then sits in HOLD until arready.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        req_ready = '0;
        arvalid   = 1'b0;
        unique case (state_q)
            RS_IDLE: begin
                if (pick_found && !areset) begin
                    req_ready[pick] = 1'b1;
                    sel_d           = pick;
                    arid_d          = req_id[pick*AXI_ID_W +: AXI_ID_W];
                    araddr_d        = req_addr[pick*AXI_ADDR_W +: AXI_ADDR_W];
                    arlen_d         = req_len[pick*4 +: 4];
                    arsize_d        = req_size[pick*3 +: 3];
                    state_d         = RS_HOLD;
                end
            end
            RS_HOLD: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = RS_IDLE;
                end
            end
            default: state_d = RS_IDLE;
        endcase
    end

    always_comb begin
        ar_hs    = arvalid & arready;
        r_hs     = rvalid & rready;
        rid_busy = id_busy_q[rid];
        r_done   = r_hs & rlast & rid_busy;

        // Clear before set so an AR reusing the completing ID stays busy.
        id_busy_d = id_busy_q;
        if (r_done) begin
            id_busy_d[rid] = 1'b0;
        end
        if (ar_hs) begin
            id_busy_d[arid_q] = 1'b1;
        end

        outst_cnt_d = outst_cnt_q;
        if (ar_hs && !r_done) begin
            outst_cnt_d = outst_cnt_q + CNT_W'(1);
        end else if (!ar_hs && r_done) begin
            outst_cnt_d = outst_cnt_q - CNT_W'(1);
        end

        rsp_done_d = '0;
        if (r_done) begin
            rsp_done_d[owner_tbl_q[rid]] = 1'b1;
        end
        err_d = r_hs & ~rid_busy;

        rr_ptr_d = rr_ptr_q;
        if (ar_hs && !(PrioEn && (sel_q == '0))) begin
            rr_ptr_d = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= RS_IDLE;
            id_busy_q   <= '0;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            outst_cnt_q <= '0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            rsp_done_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_busy_q   <= id_busy_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            outst_cnt_q <= outst_cnt_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            rsp_done_q  <= rsp_done_d;
            err_q       <= err_d;
        end
    end

    // Entries are only meaningful while the matching id_busy bit is set.
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            owner_tbl_q[arid_q] <= sel_q;
        end
    end

    assign arid          = arid_q;
    assign araddr        = araddr_q;
    assign arlen         = arlen_q;
    assign arsize        = arsize_q;
    assign arburst       = AR_BURST_INCR;
    assign arlock        = 1'b0;
    assign arcache       = AR_CACHE_DEF;
    assign arprot        = 3'b000;
    assign rsp_sel       = owner_tbl_q[rid];
    assign rsp_done      = rsp_done_q;
    assign outst_cnt     = outst_cnt_q;
    assign err_unexp_rid = err_q;

endmodule

// File: tb/tb_apb2axi_rd_scheduler.sv
// Randomized bench for apb2axi_rd_scheduler against a cycle-level behavioural model.
module tb_apb2axi_rd_scheduler;

    localparam int N    = 4;
    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int SW   = 2;
    localparam int CW   = 2;

`ifdef APB2AXI_RD_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            aclk, areset;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*IW-1:0] req_id;
    logic [N*4-1:0]  req_len;
    logic [N*3-1:0]  req_size;
    logic [IW-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [3:0]      arlen, arcache;
    logic [2:0]      arsize, arprot;
    logic [1:0]      arburst;
    logic            arlock, arvalid, arready;
    logic [IW-1:0]   rid;
    logic            rvalid, rready, rlast;
    logic [SW-1:0]   rsp_sel;
    logic [N-1:0]    rsp_done;
    logic [CW-1:0]   outst_cnt;
    logic            err_unexp_rid;

    apb2axi_rd_scheduler #(
        .N_REQ      (N),
        .MAX_OUTST  (MAXO),
        .AXI_ADDR_W (AW),
        .AXI_ID_W   (IW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_id        (req_id),
        .req_len       (req_len),
        .req_size      (req_size),
        .arid          (arid),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .arlock        (arlock),
        .arcache       (arcache),
        .arprot        (arprot),
        .arvalid       (arvalid),
        .arready       (arready),
        .rid           (rid),
        .rvalid        (rvalid),
        .rready        (rready),
        .rlast         (rlast),
        .rsp_sel       (rsp_sel),
        .rsp_done      (rsp_done),
        .outst_cnt     (outst_cnt),
        .err_unexp_rid (err_unexp_rid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: which IDs are in flight, who owns them, and the pending AR.
    bit            m_busy [16];
    int            m_owner[16];
    int            m_cnt, m_ptr, m_sel;
    bit            m_hold, m_err;
    logic [IW-1:0] m_id;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_len;
    logic [2:0]    m_size;
    logic [N-1:0]  m_done;
    int            ids_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 16; k++) begin
            m_busy[k]  = 1'b0;
            m_owner[k] = 0;
        end
        m_cnt = 0; m_ptr = 0; m_sel = 0; m_hold = 1'b0; m_err = 1'b0;
        m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_done = '0;
        ids_q.delete();
    endtask

    function automatic int model_pick();
        bit el[N];
        for (int i = 0; i < N; i++) begin
            el[i] = req_valid[i] && !m_busy[req_id[i*IW +: IW]] && (m_cnt < MAXO);
        end
        if (PRIO && el[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (el[j] && !(PRIO && j == 0)) return j;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs applied; checks outputs, advances model one clock.
    task automatic step();
        int           p;
        logic [N-1:0] exp_ready;
        bit           rb;
        #1;
        p = m_hold ? -1 : model_pick();
        exp_ready = '0;
        if (p >= 0) exp_ready[p] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("arvalid", 64'(arvalid), 64'(m_hold));
        if (m_hold) begin
            check_eq("arid", 64'(arid), 64'(m_id));
            check_eq("araddr", 64'(araddr), 64'(m_addr));
            check_eq("arlen", 64'(arlen), 64'(m_len));
            check_eq("arsize", 64'(arsize), 64'(m_size));
        end
        check_eq("outst_cnt", 64'(outst_cnt), 64'(m_cnt));
        check_eq("rsp_done", 64'(rsp_done), 64'(m_done));
        check_eq("err_unexp_rid", 64'(err_unexp_rid), 64'(m_err));
        rb = m_busy[rid];
        if (rb) check_eq("rsp_sel", 64'(rsp_sel), 64'(m_owner[rid]));

        m_done = '0;
        m_err  = rvalid && rready && !rb;
        if (rvalid && rready && rlast && rb) begin
            m_busy[rid] = 1'b0;
            m_cnt--;
            m_done[m_owner[rid]] = 1'b1;
            for (int k = 0; k < ids_q.size(); k++) begin
                if (ids_q[k] == int'(rid)) begin
                    ids_q.delete(k);
                    break;
                end
            end
        end
        if (m_hold && arready) begin
            m_busy[m_id]  = 1'b1;
            m_owner[m_id] = m_sel;
            m_cnt++;
            if (!(PRIO && m_sel == 0)) m_ptr = (m_sel + 1) % N;
            m_hold = 1'b0;
            ids_q.push_back(int'(m_id));
        end else if (p >= 0) begin
            m_hold = 1'b1;
            m_sel  = p;
            m_id   = req_id[p*IW +: IW];
            m_addr = req_addr[p*AW +: AW];
            m_len  = req_len[p*4 +: 4];
            m_size = req_size[p*3 +: 3];
        end
        @(negedge aclk);
    endtask

    task automatic drive_quiet();
        req_valid = '0; req_addr = '0; req_id = '0; req_len = '0; req_size = '0;
        arready = 1'b0; rid = '0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic set_req(input int i, input int id, input logic [AW-1:0] addr,
                           input int len);
        req_valid[i]         = 1'b1;
        req_id[i*IW +: IW]   = IW'(id);
        req_addr[i*AW +: AW] = addr;
        req_len[i*4 +: 4]    = 4'(len);
        req_size[i*3 +: 3]   = 3'd2;
    endtask

    task automatic r_beat(input int id, input bit last);
        rvalid = 1'b1; rready = 1'b1; rid = IW'(id); rlast = last;
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = ($urandom_range(0, 3) != 0);
            req_id[i*IW +: IW]   = IW'($urandom_range(0, 7));
            req_addr[i*AW +: AW] = $urandom;
            req_len[i*4 +: 4]    = 4'($urandom_range(0, 15));
            req_size[i*3 +: 3]   = 3'($urandom_range(0, 7));
        end
        arready = ($urandom_range(0, 2) != 0);
        rid     = IW'($urandom_range(0, 15));
        rvalid  = ($urandom_range(0, 1) != 0);
        rready  = ($urandom_range(0, 3) != 0);
        rlast   = ($urandom_range(0, 2) == 0);
        if (ids_q.size() > 0 && $urandom_range(0, 7) != 0) begin
            rid = IW'(ids_q[$urandom_range(0, ids_q.size() - 1)]);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        model_clear();
    endtask

    initial begin
        drive_quiet();
        areset = 1'b1;
        model_clear();
        do_reset();
        step();
        check_eq("arburst", 64'(arburst), 64'h1);
        check_eq("arlock", 64'(arlock), 64'h0);
        check_eq("arcache", 64'(arcache), 64'h3);
        check_eq("arprot", 64'(arprot), 64'h0);

        // Single requester: grant, AR held across stalled arready, then a 4-beat burst.
        set_req(0, 3, 32'h1000, 3);
        step();
        drive_quiet();
        for (int k = 0; k < 3; k++) step();
        arready = 1'b1;
        step();
        drive_quiet();
        for (int k = 0; k < 4; k++) begin
            r_beat(3, k == 3);
            step();
        end
        drive_quiet();
        step();
        step();

        // Unexpected ID.
        r_beat(7, 1'b1);
        step();
        drive_quiet();
        step();
        step();

        // Reset while an AR is held with another burst in flight.
        set_req(1, 2, 32'h2000, 1);
        arready = 1'b1;
        step();
        step();
        drive_quiet();
        set_req(2, 4, 32'h3000, 0);
        step();
        drive_quiet();
        step();
        do_reset();
        step();
        r_beat(2, 1'b1);
        step();
        drive_quiet();
        step();

        for (int c = 0; c < 4000; c++) begin
            drive_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
